// File: rtl/uart_com.sv
// uart_com: board UART for the COM port of the memory controller.
// 8N1 transmitter, synchronised 8N1 receiver, small receive FIFO.
`timescale 1ns/1ps
module uart_com #(
   parameter int CLK_DIV       = 434,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic       clk50M,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_txd,
   input  logic [7:0] com_data_out,
   input  logic       enable_com_write,
   input  logic       int_com_ack,
   output logic [7:0] com_data_in,
   output logic       com_read_ready,
   output logic       com_write_ready,
   output logic       com_int,
   output logic       rx_overrun
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t     tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          txd_n;

   rx_state_t     rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_s1, rx_s2;
   logic          push;

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [7:0]    mem [RX_FIFO_DEPTH];
   logic          ack_q;
   logic          empty, full, pop, wr_en;

   // TX next state: the serial line is registered from the next state so it never glitches
   always_comb begin
      tx_state_n      = tx_state;
      tx_cnt_n        = tx_cnt + CW'(1);
      tx_bit_n        = tx_bit;
      tx_sh_n         = tx_sh;
      com_write_ready = 1'b0;
      unique case (tx_state)
         TX_IDLE: begin
            com_write_ready = 1'b1;
            tx_cnt_n        = '0;
            if (enable_com_write) begin
               tx_sh_n    = com_data_out;
               tx_bit_n   = '0;
               tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == DIV_LAST) begin
               tx_cnt_n   = '0;
               tx_state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_cnt == DIV_LAST) begin
               tx_cnt_n = '0;
               tx_sh_n  = {1'b0, tx_sh[7:1]};
               tx_bit_n = tx_bit + 3'd1;
               if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_cnt == DIV_LAST) begin
               tx_cnt_n   = '0;
               tx_state_n = TX_IDLE;
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
      unique case (tx_state_n)
         TX_START: txd_n = 1'b0;
         TX_DATA:  txd_n = tx_sh_n[0];
         default:  txd_n = 1'b1;
      endcase
   end

   // TX state and datapath registers
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         uart_txd <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         uart_txd <= txd_n;
      end
   end

   // two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= uart_rxd;
         rx_s2 <= rx_s1;
      end
   end

   // RX next state: mid-bit sampling, start-bit glitch rejection, stop-bit framing check
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + CW'(1);
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      push       = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (!rx_s2) rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt == DIV_LAST) begin
               rx_cnt_n = '0;
               rx_sh_n  = {rx_s2, rx_sh[7:1]};
               rx_bit_n = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == DIV_LAST) begin
               rx_cnt_n   = '0;
               push       = rx_s2;
               rx_state_n = RX_IDLE;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // RX state and datapath registers
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop   = int_com_ack && !ack_q && !empty;
   assign wr_en = push && (!full || pop);

   // FIFO pointers, ack edge register and sticky overrun flag
   always_ff @(posedge clk50M or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ack_q      <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         ack_q <= int_com_ack;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop) rx_overrun <= 1'b1;
      end
   end

   // FIFO storage; contents are meaningless while the pointers say empty
   always_ff @(posedge clk50M) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_sh;
   end

   assign com_read_ready = !empty;
   assign com_int        = !empty;
   assign com_data_in    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_com.sv
// tb_uart_com: scoreboard bench for uart_com at CLK_DIV=8, depth 4.
// Directed frames; TX and RX monitors pop expected bytes from queues.
`timescale 1ns/1ps
module tb_uart_com;

   localparam int DIV = 8;

   logic       clk50M = 1'b0;
   logic       rst = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       uart_txd;
   logic [7:0] com_data_out = 8'h00;
   logic       enable_com_write = 1'b0;
   logic       int_com_ack;
   logic       ack_man = 1'b0;
   logic       ack_mon = 1'b0;
   logic [7:0] com_data_in;
   logic       com_read_ready;
   logic       com_write_ready;
   logic       com_int;
   logic       rx_overrun;

   int         n_total = 0;
   int         n_pass = 0;
   logic [7:0] rx_exp_q[$];
   logic [7:0] tx_exp_q[$];
   bit         ack_en = 1'b0;
   bit         tx_mon_en = 1'b0;
   bit         mon_busy = 1'b0;
   logic       wr_prev = 1'b1;
   logic [9:0] tx_frame;

   assign int_com_ack = ack_man | ack_mon;

   always #10 clk50M = ~clk50M;

   uart_com #(
      .CLK_DIV(DIV),
      .RX_FIFO_DEPTH(4)
   ) dut (
      .clk50M(clk50M),
      .rst(rst),
      .uart_rxd(uart_rxd),
      .uart_txd(uart_txd),
      .com_data_out(com_data_out),
      .enable_com_write(enable_com_write),
      .int_com_ack(int_com_ack),
      .com_data_in(com_data_in),
      .com_read_ready(com_read_ready),
      .com_write_ready(com_write_ready),
      .com_int(com_int),
      .rx_overrun(rx_overrun)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // call at a negedge; drives start, 8 data bits LSB first, stop
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = f[i];
         repeat (DIV) @(negedge clk50M);
      end
      uart_rxd = 1'b1;
   endtask

   task automatic wait_drained(input string name, input int budget);
      int n;
      n = 0;
      while ((rx_exp_q.size() != 0 || mon_busy || com_read_ready) && n < budget) begin
         @(negedge clk50M);
         n++;
      end
      chk(name, 16'(n < budget), 16'h1);
   endtask

   // RX monitor: compare head byte, then ack for 3 cycles (one pop expected)
   initial forever begin
      @(negedge clk50M);
      if (ack_en && rst && com_read_ready) begin
         mon_busy = 1'b1;
         chk("rx_int", 16'(com_int), 16'h1);
         if (rx_exp_q.size() == 0) begin
            n_total++;
            $display("FAIL rx_unexpected: got byte %h expected none", com_data_in);
         end else begin
            chk("rx_data", 16'(com_data_in), 16'(rx_exp_q.pop_front()));
         end
         ack_mon = 1'b1;
         repeat (3) @(negedge clk50M);
         ack_mon = 1'b0;
         if (rx_exp_q.size() == 0) begin
            chk("rx_empty_ready", 16'(com_read_ready), 16'h0);
            chk("rx_empty_data", 16'(com_data_in), 16'h0);
         end
         mon_busy = 1'b0;
      end
   end

   // TX monitor: on frame start check line and ready flag every cycle
   initial forever begin
      @(negedge clk50M);
      if (tx_mon_en && rst && !com_write_ready && wr_prev) begin
         if (tx_exp_q.size() == 0) begin
            n_total++;
            $display("FAIL tx_unexpected: got a frame expected none");
         end else begin
            tx_frame = {1'b1, tx_exp_q.pop_front(), 1'b0};
            for (int i = 0; i < 10 * DIV; i++) begin
               if (i > 0) @(negedge clk50M);
               chk("tx_line", 16'({uart_txd, com_write_ready}), 16'({tx_frame[i / DIV], 1'b0}));
            end
            @(negedge clk50M);
            chk("tx_ready_after", 16'(com_write_ready), 16'h1);
         end
      end
      wr_prev = com_write_ready;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk50M);
      chk("rst_txd", 16'(uart_txd), 16'h1);
      chk("rst_wr_ready", 16'(com_write_ready), 16'h1);
      chk("rst_rd_ready", 16'(com_read_ready), 16'h0);
      chk("rst_int", 16'(com_int), 16'h0);
      chk("rst_data", 16'(com_data_in), 16'h0);
      chk("rst_overrun", 16'(rx_overrun), 16'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk50M);

      // TX 8'hA5, second strobe mid-frame must be ignored
      tx_mon_en = 1'b1;
      tx_exp_q.push_back(8'hA5);
      com_data_out = 8'hA5;
      enable_com_write = 1'b1;
      @(negedge clk50M);
      enable_com_write = 1'b0;
      repeat (30) @(negedge clk50M);
      com_data_out = 8'hFF;
      enable_com_write = 1'b1;
      @(negedge clk50M);
      enable_com_write = 1'b0;
      n = 0;
      while (!com_write_ready && n < 300) begin
         @(negedge clk50M);
         n++;
      end
      chk("tx_done", 16'(com_write_ready), 16'h1);
      repeat (30) @(negedge clk50M);
      chk("tx_consumed", 16'(tx_exp_q.size()), 16'h0);

      // RX 8'h3C with a 3-cycle ack
      ack_en = 1'b1;
      rx_exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_drained("rx_3c_drain", 100);

      // fill FIFO, then ack rising edge coincident with push of 8'h77
      ack_en = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      chk("full_ready", 16'(com_read_ready), 16'h1);
      chk("full_head", 16'(com_data_in), 16'h11);
      fork
         send_frame(8'h77, 1'b1);
         begin
            repeat (78) @(negedge clk50M);
            ack_man = 1'b1;
            repeat (3) @(negedge clk50M);
            ack_man = 1'b0;
         end
      join
      chk("coincident_no_overrun", 16'(rx_overrun), 16'h0);
      rx_exp_q.push_back(8'h22);
      rx_exp_q.push_back(8'h33);
      rx_exp_q.push_back(8'h44);
      rx_exp_q.push_back(8'h77);
      ack_en = 1'b1;
      wait_drained("coincident_drain", 200);

      // overrun: 5 bytes into a 4-deep FIFO
      ack_en = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      chk("overrun_set", 16'(rx_overrun), 16'h1);
      for (int i = 1; i <= 4; i++) rx_exp_q.push_back(8'(i));
      ack_en = 1'b1;
      wait_drained("overrun_drain", 200);
      chk("overrun_sticky", 16'(rx_overrun), 16'h1);

      // glitch and framing error, then a good frame
      uart_rxd = 1'b0;
      repeat (2) @(negedge clk50M);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk50M);
      chk("glitch_no_push", 16'(com_read_ready), 16'h0);
      send_frame(8'h55, 1'b0);
      repeat (20) @(negedge clk50M);
      chk("framing_no_push", 16'(com_read_ready), 16'h0);
      rx_exp_q.push_back(8'h66);
      send_frame(8'h66, 1'b1);
      wait_drained("good_after_framing", 100);

      // reset mid TX frame with a byte pending
      ack_en = 1'b0;
      tx_mon_en = 1'b0;
      send_frame(8'h99, 1'b1);
      chk("pre_rst_ready", 16'(com_read_ready), 16'h1);
      com_data_out = 8'h00;
      enable_com_write = 1'b1;
      @(negedge clk50M);
      enable_com_write = 1'b0;
      repeat (20) @(negedge clk50M);
      chk("mid_frame_txd", 16'(uart_txd), 16'h0);
      chk("mid_frame_wr", 16'(com_write_ready), 16'h0);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_txd", 16'(uart_txd), 16'h1);
      chk("arst_wr_ready", 16'(com_write_ready), 16'h1);
      chk("arst_rd_ready", 16'(com_read_ready), 16'h0);
      chk("arst_int", 16'(com_int), 16'h0);
      chk("arst_data", 16'(com_data_in), 16'h0);
      chk("arst_overrun", 16'(rx_overrun), 16'h0);
      @(negedge clk50M);
      rst = 1'b1;
      repeat (5) @(negedge clk50M);
      chk("post_rst_txd", 16'(uart_txd), 16'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
